// File: rtl/vga_pkg.sv
// Default 800x600@60 timing constants shared by the VGA raster generator.
// Modules take these as parameter defaults so other modes can be built from the same RTL.
package vga_pkg;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BP     = 23;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

  localparam int   DEF_CNT_W    = 11;
  localparam logic DEF_SYNC_POL = 1'b1;

endpackage

// File: rtl/vga_axis_ctr.sv
// One raster axis: a wrap counter advanced by carry_i, with sync/blank decoded
// from the next-state count so the registered flags line up with count_o.
module vga_axis_ctr
  import vga_pkg::*;
#(
  parameter int   CNT_W    = DEF_CNT_W,
  parameter int   ACTIVE   = DEF_H_ACTIVE,
  parameter int   FP       = DEF_H_FP,
  parameter int   SYNC     = DEF_H_SYNC,
  parameter int   BP       = DEF_H_BP,
  parameter logic SYNC_POL = DEF_SYNC_POL
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             carry_i,
  output logic [CNT_W-1:0] count_o,
  output logic             sync_o,
  output logic             blnk_o,
  output logic             carry_o
);

  localparam int               TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_FIRST = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             sync_q, blnk_q;

  assign carry_o = carry_i && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (carry_i) begin
      count_d = carry_o ? '0 : count_q + ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
      sync_q  <= ~SYNC_POL;
      blnk_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      sync_q  <= ((count_d >= SYNC_FIRST) && (count_d <= SYNC_LAST)) ? SYNC_POL : ~SYNC_POL;
      blnk_q  <= (count_d >= ACT_END);
    end
  end

  assign count_o = count_q;
  assign sync_o  = sync_q;
  assign blnk_o  = blnk_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: two chained axis counters plus
// start-of-line/frame strobes and a completed-frame counter, all registered.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = DEF_SYNC_POL,
  parameter int   CNT_W    = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             pix_en_i,
  output logic [CNT_W-1:0] hcount_o,
  output logic [CNT_W-1:0] vcount_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             hblnk_o,
  output logic             vblnk_o,
  output logic             sol_o,
  output logic             sof_o,
  output logic [15:0]      frame_cnt_o
);

  logic        h_carry, v_carry;
  logic        sol_q, sof_q;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  vga_axis_ctr #(
    .CNT_W(CNT_W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .SYNC_POL(SYNC_POL)
  ) u_h_ctr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .carry_i (pix_en_i),
    .count_o (hcount_o),
    .sync_o  (hsync_o),
    .blnk_o  (hblnk_o),
    .carry_o (h_carry)
  );

  // The vertical axis only moves on the edge where the line wraps.
  vga_axis_ctr #(
    .CNT_W(CNT_W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .SYNC_POL(SYNC_POL)
  ) u_v_ctr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .carry_i (h_carry),
    .count_o (vcount_o),
    .sync_o  (vsync_o),
    .blnk_o  (vblnk_o),
    .carry_o (v_carry)
  );

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (v_carry) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // Carries already include pix_en, so stalled cycles register zero strobes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sol_q       <= 1'b0;
      sof_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      sol_q       <= h_carry;
      sof_q       <= v_carry;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign sol_o       = sol_q;
  assign sof_o       = sof_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 800x600 instance for line-level timing and a tiny
// 24x15 mode instance so whole frames, stalls and frame wraps fit in a short run.
`timescale 1ns/100ps
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic        rstN, pixEn;
  logic [10:0] hDef, vDef, hSm, vSm;
  logic        hsDef, vsDef, hbDef, vbDef, solDef, sofDef;
  logic        hsSm, vsSm, hbSm, vbSm, solSm, sofSm;
  logic [15:0] fcDef, fcSm;
  int          testCount = 0;
  int          failCount = 0;

  always #5 clk = ~clk;

  vga_timing_gen dutDef (
    .clk_i(clk), .rst_n_i(rstN), .pix_en_i(pixEn),
    .hcount_o(hDef), .vcount_o(vDef), .hsync_o(hsDef), .vsync_o(vsDef),
    .hblnk_o(hbDef), .vblnk_o(vbDef), .sol_o(solDef), .sof_o(sofDef), .frame_cnt_o(fcDef)
  );

  // Small mode: hsync on h 18..20 of 24, vsync on lines 11..12 of 15, 360 clk/frame.
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1), .CNT_W(11)
  ) dutSmall (
    .clk_i(clk), .rst_n_i(rstN), .pix_en_i(pixEn),
    .hcount_o(hSm), .vcount_o(vSm), .hsync_o(hsSm), .vsync_o(vsSm),
    .hblnk_o(hbSm), .vblnk_o(vbSm), .sol_o(solSm), .sof_o(sofSm), .frame_cnt_o(fcSm)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstVal, input logic enVal);
    rstN  = rstVal;
    pixEn = enVal;
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hsCount, hsFirst, hsLast, hbCount, solCount, vsCount;
    int vbCount, sofCount, vsFirst, vsLast, line;

    // Reset held for five edges: everything must sit at its reset value.
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      stepClk();
      checkOutput("rst def counts", {hDef, vDef}, 0);
      checkOutput("rst def flags", {hsDef, vsDef, hbDef, vbDef, solDef, sofDef}, 0);
      checkOutput("rst def frame", fcDef, 0);
      checkOutput("rst sm counts", {hSm, vSm}, 0);
      checkOutput("rst sm flags", {hsSm, vsSm, hbSm, vbSm, solSm, sofSm}, 0);
      checkOutput("rst sm frame", fcSm, 0);
    end
    applyStimulus(1'b1, 1'b1);

    // Two full default lines; n is the number of edges since release.
    hsCount = 0; hsFirst = -1; hsLast = -1; hbCount = 0; solCount = 0; vsCount = 0;
    for (int n = 1; n <= 2112; n++) begin
      stepClk();
      if (hsDef) begin
        hsCount++;
        if (hsFirst < 0) hsFirst = n % 1056;
        hsLast = n % 1056;
      end
      if (hbDef) hbCount++;
      if (solDef) solCount++;
      if (vsDef) vsCount++;
      case (n)
        1: begin
          checkOutput("first edge hcount", hDef, 1);
          checkOutput("first edge vcount", vDef, 0);
          checkOutput("first edge sol/sof", {solDef, sofDef}, 0);
          checkOutput("first edge sm hcount", hSm, 1);
        end
        799: checkOutput("hblnk before 800", hbDef, 0);
        800: checkOutput("hblnk at 800", {hDef, 4'b0, hbDef}, {11'd800, 4'b0, 1'b1});
        1055: begin
          checkOutput("line end counts", {hDef, vDef}, {11'd1055, 11'd0});
          checkOutput("line end sol", solDef, 0);
        end
        1056: begin
          checkOutput("line wrap counts", {hDef, vDef}, {11'd0, 11'd1});
          checkOutput("line wrap sol/sof", {solDef, sofDef}, 2'b10);
          checkOutput("line wrap hblnk", hbDef, 0);
        end
        1057: checkOutput("sol one clk", {hDef, 4'b0, solDef}, {11'd1, 4'b0, 1'b0});
        2112: begin
          checkOutput("def at 2112", {hDef, vDef}, {11'd0, 11'd2});
          checkOutput("def sol at 2112", solDef, 1);
          checkOutput("def frame at 2112", fcDef, 0);
          checkOutput("sm at 2112", {hSm, vSm}, {11'd0, 11'd13});
          checkOutput("sm strobes at 2112", {solSm, sofSm}, 2'b10);
          checkOutput("sm frame at 2112", fcSm, 5);
        end
        default: ;
      endcase
    end
    checkOutput("hsync first h", hsFirst, 840);
    checkOutput("hsync last h", hsLast, 967);
    checkOutput("hsync cycles", hsCount, 256);
    checkOutput("hblnk cycles", hbCount, 512);
    checkOutput("sol pulses", solCount, 2);
    checkOutput("vsync early lines", vsCount, 0);

    // Short reset pulse between edges must clear outputs without a clock.
    #2 rstN = 1'b0;
    #1;
    checkOutput("async rst def counts", {hDef, vDef}, 0);
    checkOutput("async rst def flags", {hsDef, vsDef, hbDef, vbDef, solDef, sofDef}, 0);
    checkOutput("async rst sm counts", {hSm, vSm}, 0);
    checkOutput("async rst sm flags", {hsSm, vsSm, hbSm, vbSm, solSm, sofSm}, 0);
    checkOutput("async rst sm frame", fcSm, 0);
    rstN = 1'b1;

    // One full small frame after the restart.
    vsCount = 0; vsFirst = -1; vsLast = -1; vbCount = 0; hsCount = 0; sofCount = 0; solCount = 0;
    for (int n = 1; n <= 360; n++) begin
      stepClk();
      line = (n % 360) / 24;
      if (vsSm) begin
        vsCount++;
        if (vsFirst < 0) vsFirst = line;
        vsLast = line;
      end
      if (vbSm) vbCount++;
      if (hsSm) hsCount++;
      if (sofSm) sofCount++;
      if (solSm) solCount++;
      case (n)
        1: begin
          checkOutput("restart def counts", {hDef, vDef}, {11'd1, 11'd0});
          checkOutput("restart sm counts", {hSm, vSm}, {11'd1, 11'd0});
        end
        239: checkOutput("vblnk before line 10", vbSm, 0);
        240: checkOutput("vblnk at line 10", {hSm, vSm, vbSm}, {11'd0, 11'd10, 1'b1});
        359: begin
          checkOutput("frame end counts", {hSm, vSm}, {11'd23, 11'd14});
          checkOutput("frame end sof/frame", {sofSm, fcSm}, 0);
        end
        360: begin
          checkOutput("frame wrap counts", {hSm, vSm}, 0);
          checkOutput("frame wrap strobes", {solSm, sofSm}, 2'b11);
          checkOutput("frame wrap frame_cnt", fcSm, 1);
          checkOutput("frame wrap blanks", {hbSm, vbSm}, 0);
        end
        default: ;
      endcase
    end
    checkOutput("vsync cycles", vsCount, 48);
    checkOutput("vsync first line", vsFirst, 11);
    checkOutput("vsync last line", vsLast, 12);
    checkOutput("vblnk cycles", vbCount, 120);
    checkOutput("sm hsync cycles", hsCount, 45);
    checkOutput("sof pulses", sofCount, 1);
    checkOutput("sm sol pulses", solCount, 15);

    // Stall straight after sof: the strobe must drop, counts hold.
    pixEn = 1'b0;
    stepClk();
    checkOutput("stall after sof strobes", {solSm, sofSm}, 0);
    checkOutput("stall after sof counts", {hSm, vSm}, 0);
    checkOutput("stall after sof frame", fcSm, 1);
    pixEn = 1'b1;

    for (int n = 0; n < 359; n++) stepClk();
    checkOutput("pre-stall counts", {hSm, vSm}, {11'd23, 11'd14});

    // Freeze at the last pixel of the frame for seven edges.
    pixEn = 1'b0;
    for (int i = 0; i < 7; i++) begin
      stepClk();
      checkOutput("stall counts", {hSm, vSm}, {11'd23, 11'd14});
      checkOutput("stall flags", {hsSm, vsSm, hbSm, vbSm, solSm, sofSm}, 6'b001100);
      checkOutput("stall frame", fcSm, 1);
    end
    pixEn = 1'b1;
    stepClk();
    checkOutput("resume wrap counts", {hSm, vSm}, 0);
    checkOutput("resume wrap strobes", {solSm, sofSm}, 2'b11);
    checkOutput("resume frame_cnt", fcSm, 2);
    stepClk();
    checkOutput("resume sof one clk", {hSm, 4'b0, sofSm}, {11'd1, 4'b0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
